// File: rtl/i2c_op_decoder.sv
// Passive I2C bus decoder: synchronises SCL/SDA, detects START/STOP and
// deserialises address, data and ACK bits into single-cycle pulses.
module i2c_op_decoder #(
  parameter int unsigned I2C_SLAVE_ADDR_SIZE = 7,
  parameter int unsigned I2C_BYTE_SIZE       = 8,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           scl_i,
  input  logic                           sda_i,
  output logic                           start_o,
  output logic                           stop_o,
  output logic                           op_valid_o,
  output logic [I2C_SLAVE_ADDR_SIZE-1:0] op_addr_o,
  output logic                           op_rw_o,
  output logic                           byte_valid_o,
  output logic [I2C_BYTE_SIZE-1:0]       byte_o,
  output logic                           ack_valid_o,
  output logic                           ack_o,
  output logic                           busy_o
);

  localparam int unsigned CNT_W = $clog2(I2C_BYTE_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK
  } state_t;

  logic [SYNC_STAGES-1:0]   scl_sync, sda_sync;
  logic                     scl_s, sda_s, scl_q, sda_q;
  logic                     start_det, stop_det, rise_det;
  logic                     start_ev, stop_ev, rise_ev, bit_ev;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [I2C_BYTE_SIZE-1:0] shreg_q, shreg_d, shifted;
  logic                     last_bit;
  logic                     start_d, stop_d, op_d, byte_d, ack_d, busy_d;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Idle-bus reset values keep reset release from looking like an edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // SCL rise wins over START/STOP when both lines move together
  assign rise_det  = ~scl_q & scl_s;
  assign start_det = scl_q & scl_s & sda_q & ~sda_s;
  assign stop_det  = scl_q & scl_s & ~sda_q & sda_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      start_ev <= 1'b0;
      stop_ev  <= 1'b0;
      rise_ev  <= 1'b0;
      bit_ev   <= 1'b0;
    end else begin
      start_ev <= start_det;
      stop_ev  <= stop_det;
      rise_ev  <= rise_det;
      bit_ev   <= sda_s;
    end
  end

  assign shifted  = {shreg_q[I2C_BYTE_SIZE-2:0], bit_ev};
  assign last_bit = (cnt_q == CNT_W'(I2C_BYTE_SIZE - 1));

  // Next-state and pulse decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    op_d    = 1'b0;
    byte_d  = 1'b0;
    ack_d   = 1'b0;
    busy_d  = busy_o;
    if (start_ev) begin
      start_d = 1'b1;
      busy_d  = 1'b1;
      state_d = ADDR;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (stop_ev) begin
      stop_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (rise_ev) begin
      case (state_q)
        ADDR, DATA: begin
          shreg_d = shifted;
          cnt_d   = CNT_W'(cnt_q + 1'b1);
          if (last_bit) begin
            cnt_d = '0;
            if (state_q == ADDR) begin
              op_d    = 1'b1;
              state_d = ADDR_ACK;
            end else begin
              byte_d  = 1'b1;
              state_d = DATA_ACK;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          ack_d   = 1'b1;
          state_d = DATA;
          cnt_d   = '0;
          shreg_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      start_o      <= 1'b0;
      stop_o       <= 1'b0;
      op_valid_o   <= 1'b0;
      op_addr_o    <= '0;
      op_rw_o      <= 1'b0;
      byte_valid_o <= 1'b0;
      byte_o       <= '0;
      ack_valid_o  <= 1'b0;
      ack_o        <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      start_o      <= start_d;
      stop_o       <= stop_d;
      op_valid_o   <= op_d;
      byte_valid_o <= byte_d;
      ack_valid_o  <= ack_d;
      busy_o       <= busy_d;
      if (op_d) begin
        op_addr_o <= shifted[I2C_SLAVE_ADDR_SIZE:1];
        op_rw_o   <= shifted[0];
      end
      if (byte_d) byte_o <= shifted;
      if (ack_d)  ack_o  <= ~bit_ev;
    end
  end

endmodule

// File: tb/tb_i2c_op_decoder.sv
// Directed bench for i2c_op_decoder: bit-banged I2C transfers with
// hand-computed expected operations, bytes, ACKs and pulse latencies.
module tb_i2c_op_decoder;

  localparam int unsigned H = 8;

  logic       clk = 1'b0;
  logic       rst_n_i, scl_i, sda_i;
  logic       start_o, stop_o, op_valid_o, op_rw_o, byte_valid_o;
  logic       ack_valid_o, ack_o, busy_o;
  logic [6:0] op_addr_o;
  logic [7:0] byte_o;

  i2c_op_decoder dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .start_o      (start_o),
    .stop_o       (stop_o),
    .op_valid_o   (op_valid_o),
    .op_addr_o    (op_addr_o),
    .op_rw_o      (op_rw_o),
    .byte_valid_o (byte_valid_o),
    .byte_o       (byte_o),
    .ack_valid_o  (ack_valid_o),
    .ack_o        (ack_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder
  int n_start = 0, n_stop = 0, n_op = 0, n_byte = 0, n_ack = 0;
  int onehot_bad = 0, busy_bad = 0;
  int start_seen = 0, stop_seen = 0, op_seen = 0, byte_seen = 0, ack_seen = 0;
  logic [6:0] addr_q[$];
  logic       rw_q[$];
  logic [7:0] byte_q[$];
  logic       ack_q[$];

  always @(negedge clk) begin
    if (start_o) begin n_start++; start_seen = cyc; if (!busy_o) busy_bad++; end
    if (stop_o) begin n_stop++; stop_seen = cyc; if (busy_o) busy_bad++; end
    if (op_valid_o) begin n_op++; op_seen = cyc; addr_q.push_back(op_addr_o); rw_q.push_back(op_rw_o); end
    if (byte_valid_o) begin n_byte++; byte_seen = cyc; byte_q.push_back(byte_o); end
    if (ack_valid_o) begin n_ack++; ack_seen = cyc; ack_q.push_back(ack_o); end
    if ($countones({start_o, stop_o, op_valid_o, byte_valid_o, ack_valid_o}) > 1) onehot_bad++;
  end

  int checks = 0, errors = 0;
  int drv_cyc, rise8_cyc, rise9_cyc, start_drv, stop_drv;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2);
    sda_i = b;
    wait_clk(H);
    scl_i = 1'b1;
    drv_cyc = cyc;
    wait_clk(H);
    scl_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    rise8_cyc = drv_cyc;
    send_bit(~ack);
    rise9_cyc = drv_cyc;
  endtask

  task automatic bus_start();
    wait_clk(2);
    sda_i = 1'b1;
    wait_clk(H);
    scl_i = 1'b1;
    wait_clk(H);
    sda_i = 1'b0;
    start_drv = cyc;
    wait_clk(H);
    scl_i = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(2);
    sda_i = 1'b0;
    wait_clk(H);
    scl_i = 1'b1;
    wait_clk(H);
    sda_i = 1'b1;
    stop_drv = cyc;
    wait_clk(H);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    scl_i   = 1'b1;
    sda_i   = 1'b1;
    wait_clk(3);
    checks++;
    if ({start_o, stop_o, op_valid_o, byte_valid_o, ack_valid_o, busy_o} !== 6'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000000",
        {start_o, stop_o, op_valid_o, byte_valid_o, ack_valid_o, busy_o});
    end
    checks++;
    if ({op_addr_o, op_rw_o, byte_o, ack_o} !== 17'h0) begin
      errors++; $display("FAIL reset_held: got %h expected 0", {op_addr_o, op_rw_o, byte_o, ack_o});
    end
    rst_n_i = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_write();
    int s0 = n_start, p0 = n_stop, o0 = n_op, b0 = n_byte, k0 = n_ack;
    int ai = addr_q.size(), bi = byte_q.size(), ki = ack_q.size();
    bus_start();
    send_byte(8'hA0, 1'b1);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL write_busy_mid: got %b expected 1", busy_o); end
    send_byte(8'hA5, 1'b1);
    bus_stop();
    checks++;
    if (n_start - s0 !== 1 || n_stop - p0 !== 1 || n_op - o0 !== 1 || n_byte - b0 !== 1 || n_ack - k0 !== 2) begin
      errors++; $display("FAIL write_counts: got start=%0d stop=%0d op=%0d byte=%0d ack=%0d expected 1 1 1 1 2",
        n_start - s0, n_stop - p0, n_op - o0, n_byte - b0, n_ack - k0);
    end
    checks++;
    if (addr_q[ai] !== 7'h50 || rw_q[ai] !== 1'b0) begin
      errors++; $display("FAIL write_op: got addr=%h rw=%b expected 50 0", addr_q[ai], rw_q[ai]);
    end
    checks++;
    if (byte_q[bi] !== 8'hA5) begin errors++; $display("FAIL write_byte: got %h expected a5", byte_q[bi]); end
    checks++;
    if (ack_q[ki] !== 1'b1 || ack_q[ki+1] !== 1'b1) begin
      errors++; $display("FAIL write_acks: got %b%b expected 11", ack_q[ki], ack_q[ki+1]);
    end
    checks++;
    if (busy_o !== 1'b0 || byte_o !== 8'hA5 || ack_o !== 1'b1) begin
      errors++; $display("FAIL write_end: got busy=%b byte=%h ack=%b expected 0 a5 1", busy_o, byte_o, ack_o);
    end
  endtask

  task automatic test_read();
    int ai = addr_q.size(), bi = byte_q.size(), ki = ack_q.size(), p0 = n_stop;
    bus_start();
    send_byte(8'h79, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    bus_stop();
    checks++;
    if (addr_q[ai] !== 7'h3C || rw_q[ai] !== 1'b1) begin
      errors++; $display("FAIL read_op: got addr=%h rw=%b expected 3c 1", addr_q[ai], rw_q[ai]);
    end
    checks++;
    if (byte_q.size() - bi !== 2 || byte_q[bi] !== 8'h12 || byte_q[bi+1] !== 8'h34) begin
      errors++; $display("FAIL read_bytes: got n=%0d %h %h expected 2 12 34",
        byte_q.size() - bi, byte_q[bi], byte_q[bi+1]);
    end
    checks++;
    if (ack_q.size() - ki !== 3 || ack_q[ki] !== 1'b1 || ack_q[ki+1] !== 1'b1 || ack_q[ki+2] !== 1'b0) begin
      errors++; $display("FAIL read_acks: got n=%0d %b%b%b expected 3 110",
        ack_q.size() - ki, ack_q[ki], ack_q[ki+1], ack_q[ki+2]);
    end
    checks++;
    if (n_stop - p0 !== 1 || ack_o !== 1'b0 || byte_o !== 8'h34) begin
      errors++; $display("FAIL read_end: got stops=%0d ack=%b byte=%h expected 1 0 34", n_stop - p0, ack_o, byte_o);
    end
  endtask

  task automatic test_repeated_start();
    int s0 = n_start, p0 = n_stop, ai = addr_q.size(), bi = byte_q.size();
    bus_start();
    send_byte(8'h44, 1'b1);
    send_byte(8'h5A, 1'b1);
    bus_start();
    send_byte(8'h45, 1'b1);
    checks++;
    if (busy_o !== 1'b1 || n_start - s0 !== 2 || n_stop - p0 !== 0) begin
      errors++; $display("FAIL rstart_busy: got busy=%b starts=%0d stops=%0d expected 1 2 0",
        busy_o, n_start - s0, n_stop - p0);
    end
    send_byte(8'hC3, 1'b0);
    bus_stop();
    checks++;
    if (addr_q[ai] !== 7'h22 || rw_q[ai] !== 1'b0 || addr_q[ai+1] !== 7'h22 || rw_q[ai+1] !== 1'b1) begin
      errors++; $display("FAIL rstart_ops: got %h/%b %h/%b expected 22/0 22/1",
        addr_q[ai], rw_q[ai], addr_q[ai+1], rw_q[ai+1]);
    end
    checks++;
    if (byte_q.size() - bi !== 2 || byte_q[bi] !== 8'h5A || byte_q[bi+1] !== 8'hC3) begin
      errors++; $display("FAIL rstart_bytes: got n=%0d %h %h expected 2 5a c3",
        byte_q.size() - bi, byte_q[bi], byte_q[bi+1]);
    end
  endtask

  task automatic test_partial_stop();
    int b0 = n_byte, p0 = n_stop, k0 = n_ack;
    bus_start();
    send_byte(8'hA0, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus_stop();
    checks++;
    if (n_byte - b0 !== 0 || n_stop - p0 !== 1 || n_ack - k0 !== 1) begin
      errors++; $display("FAIL partial_counts: got byte=%0d stop=%0d ack=%0d expected 0 1 1",
        n_byte - b0, n_stop - p0, n_ack - k0);
    end
    checks++;
    if (byte_o !== 8'hC3 || busy_o !== 1'b0) begin
      errors++; $display("FAIL partial_held: got byte=%h busy=%b expected c3 0", byte_o, busy_o);
    end
  endtask

  task automatic test_latency();
    bus_start();
    checks++;
    if (start_seen - start_drv !== 4) begin
      errors++; $display("FAIL lat_start: got %0d expected 4", start_seen - start_drv);
    end
    send_byte(8'hA0, 1'b1);
    checks++;
    if (op_seen - rise8_cyc !== 4 || ack_seen - rise9_cyc !== 4) begin
      errors++; $display("FAIL lat_op_ack: got %0d %0d expected 4 4", op_seen - rise8_cyc, ack_seen - rise9_cyc);
    end
    send_byte(8'h0F, 1'b1);
    checks++;
    if (byte_seen - rise8_cyc !== 4 || ack_seen - rise9_cyc !== 4) begin
      errors++; $display("FAIL lat_byte_ack: got %0d %0d expected 4 4", byte_seen - rise8_cyc, ack_seen - rise9_cyc);
    end
    bus_stop();
    checks++;
    if (stop_seen - stop_drv !== 4) begin
      errors++; $display("FAIL lat_stop: got %0d expected 4", stop_seen - stop_drv);
    end
  endtask

  task automatic test_idle_and_reset();
    int tot0 = n_start + n_stop + n_op + n_byte + n_ack;
    int s0, o0, ai;
    for (int i = 0; i < 20; i++) begin
      wait_clk(H);
      scl_i = 1'b0;
      wait_clk(H);
      scl_i = 1'b1;
    end
    wait_clk(H);
    checks++;
    if (n_start + n_stop + n_op + n_byte + n_ack - tot0 !== 0) begin
      errors++; $display("FAIL idle_scl: got %0d pulses expected 0", n_start + n_stop + n_op + n_byte + n_ack - tot0);
    end
    s0 = n_start;
    o0 = n_op;
    bus_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (busy_o !== 1'b1 || op_addr_o !== 7'h50) begin
      errors++; $display("FAIL prereset_state: got busy=%b addr=%h expected 1 50", busy_o, op_addr_o);
    end
    wait_clk(3);
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({start_o, stop_o, op_valid_o, byte_valid_o, ack_valid_o, busy_o, op_addr_o, op_rw_o, byte_o, ack_o} !== 23'h0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%b addr=%h rw=%b byte=%h ack=%b expected all 0",
        busy_o, op_addr_o, op_rw_o, byte_o, ack_o);
    end
    scl_i = 1'b1;
    sda_i = 1'b1;
    wait_clk(10);
    rst_n_i = 1'b1;
    wait_clk(10);
    checks++;
    if (n_start - s0 !== 1 || n_op - o0 !== 0) begin
      errors++; $display("FAIL midreset_counts: got starts=%0d ops=%0d expected 1 0", n_start - s0, n_op - o0);
    end
    ai = addr_q.size();
    bus_start();
    send_byte(8'hFE, 1'b1);
    bus_stop();
    checks++;
    if (addr_q.size() - ai !== 1 || addr_q[ai] !== 7'h7F || rw_q[ai] !== 1'b0 || ack_o !== 1'b1) begin
      errors++; $display("FAIL postreset_op: got n=%0d addr=%h rw=%b ack=%b expected 1 7f 0 1",
        addr_q.size() - ai, addr_q[ai], rw_q[ai], ack_o);
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (onehot_bad !== 0 || busy_bad !== 0) begin
      errors++; $display("FAIL pulse_rules: got onehot_bad=%0d busy_bad=%0d expected 0 0", onehot_bad, busy_bad);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_repeated_start();
    test_partial_stop();
    test_latency();
    test_idle_and_reset();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/i2c_op_decoder.md
# i2c_op_decoder

Passive I2C bus front-end for the I2C verification environment and for the I2C master bench harness. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP conditions. It deserialises the address byte into an operation (7-bit address plus rw, low = write, high = read) and the data bytes that follow, including each ACK/NACK bit. Its outputs feed the i2c_op_t-based operation consumer and the transaction monitor directly downstream.

## Interface
- I2C_SLAVE_ADDR_SIZE, 7, width of the slave address field
- I2C_BYTE_SIZE, 8, bits per byte on the bus
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (minimum 2)
- clk_i  in  1  system clock; all logic on rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- scl_i  in  1  raw bus SCL, asynchronous to clk_i
- sda_i  in  1  raw bus SDA, asynchronous to clk_i
- start_o  out  1  one-cycle pulse on START or repeated START
- stop_o  out  1  one-cycle pulse on STOP
- op_valid_o  out  1  one-cycle pulse when the address byte is complete
- op_addr_o  out  I2C_SLAVE_ADDR_SIZE  address, MSB first on the bus; held until the next op_valid_o
- op_rw_o  out  1  8th address-phase bit; held until the next op_valid_o
- byte_valid_o  out  1  one-cycle pulse when a data byte is complete
- byte_o  out  I2C_BYTE_SIZE  data byte, MSB first; held until the next byte_valid_o
- ack_valid_o  out  1  one-cycle pulse on the 9th bit of any byte (address or data)
- ack_o  out  1  1 = ACK (SDA low), 0 = NACK; held until the next ack_valid_o
- busy_o  out  1  high from START until STOP

## Operation
- Synchroniser: SYNC_STAGES flops per line plus one history flop, giving scl_s/scl_q and sda_s/sda_q. All of these reset to 1 (idle bus), so reset release never creates a false edge.
- Events are evaluated each cycle:
  - START: scl_q & scl_s & sda_q & ~sda_s.
  - STOP: scl_q & scl_s & ~sda_q & sda_s.
  - SCL rise: ~scl_q & scl_s; this samples sda_s.
- If SCL and SDA change in the same cycle, the event is an SCL rise, not START or STOP. SDA is sampled at its new value.
- States:
  - IDLE → ADDR on START.
  - ADDR: shifts on each SCL rise; bit counter runs 0..7. On the 8th bit: op_addr_o = bits[7:1], op_rw_o = bit 0, pulse op_valid_o, go to ADDR_ACK.
  - ADDR_ACK: next SCL rise samples ack_o = ~sda_s, pulses ack_valid_o, then → DATA.
  - DATA: 8 SCL rises; on the 8th, update byte_o, pulse byte_valid_o, → DATA_ACK.
  - DATA_ACK: next SCL rise updates ack_o, pulses ack_valid_o, → DATA. The block always returns to DATA, including after a NACK; only STOP or START ends the transfer.
- START in any state other than IDLE (repeated START): pulse start_o, clear the bit counter and shift register, → ADDR. busy_o stays high.
- STOP in any state: pulse stop_o, → IDLE, discard any partial byte. Held outputs are not modified. STOP in IDLE still pulses stop_o.
- In IDLE, SCL rises are ignored and there is no output activity.
- At most one of the pulses start_o, stop_o, op_valid_o, byte_valid_o, ack_valid_o is high in any cycle.

## Timing
- Reset values: every output is 0, state = IDLE, counter = 0, shift register = 0.
- Reset mid-transaction: outputs go to 0 immediately (asynchronous). After release the block waits in IDLE for a fresh START.
- Latency: an output pulse is registered SYNC_STAGES+2 clk_i cycles after the pin transition that causes it (default 4). All pulses are exactly 1 cycle wide.
- busy_o rises in the same cycle as the start_o pulse and falls in the same cycle as the stop_o pulse.
- Held data outputs (op_addr_o, op_rw_o, byte_o, ack_o) update in the same cycle as their valid pulse.
- Bus requirement: SCL high and low periods of at least SYNC_STAGES+2 clk_i cycles. Faster buses are unsupported and their behaviour is undefined.

## Test plan
- Write 0x50, data 0xA5 ACKed, then STOP → start_o; op_valid_o with op_addr_o=0x50, op_rw_o=0; ack_o=1; byte_valid_o with byte_o=0xA5; ack_o=1; stop_o; busy_o 1→0.
- Read 0x3C, bytes 0x12 (ACK) then 0x34 (NACK), then STOP → op_rw_o=1; byte_o=0x12, ack_o=1; byte_o=0x34, ack_o=0; stop_o.
- Write 0x22, 1 byte, repeated START, read 0x22 → two start_o pulses, busy_o high throughout; second op_valid_o has op_rw_o=1.
- STOP after 3 bits of a data byte → no byte_valid_o; stop_o; state IDLE; byte_o keeps its previous value.
- 20 SCL pulses with no START, then rst_n_i low during an address byte → no pulses during the SCL pulses. Reset clears all outputs to 0. The next START plus address 0x7F decodes correctly.
- Check pulse latency of exactly 4 cycles from each pin edge, with SYNC_STAGES=2.
